// File: rtl/cdic_audio_pkg.sv
// Shared types and constants for the CDIC audio playback path.
package cdic_audio_pkg;

  localparam int unsigned PCM_W = 16;

  typedef struct packed {
    logic [PCM_W-1:0] left;
    logic [PCM_W-1:0] right;
  } stereo_t;

  typedef enum logic [1:0] {
    StIdle,
    StPrefill,
    StPlay,
    StUnderrun
  } player_state_e;

  localparam logic RATE_37K8 = 1'b0;
  localparam logic RATE_44K1 = 1'b1;

endpackage

// File: rtl/cdic_sample_fifo.sv
// Single-clock FIFO of stereo pairs; a push while full is refused even if a pop
// happens in the same cycle. clear is synchronous and drops any same-cycle push.
module cdic_sample_fifo #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clear,
  input  logic                push,
  input  logic [DATA_W-1:0]   push_data,
  input  logic                pop,
  output logic [DATA_W-1:0]   pop_data,
  output logic                full,
  output logic                empty,
  output logic [DEPTH_LOG2:0] count
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

  logic [DATA_W-1:0]     mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q;
  logic                  push_ok, pop_ok;

  // count never exceeds DEPTH, so its MSB alone marks full
  assign full     = count_q[DEPTH_LOG2];
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign push_ok  = push & ~full & ~clear;
  assign pop_ok   = pop & ~empty & ~clear;
  assign pop_data = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/cdic_sample_player.sv
// Releases one buffered stereo pair per selected sample tick, with prefill and underrun handling.
// Build option: CDIC_UNDERRUN_RAMP_EN makes underrun ticks decay the held outputs toward zero.
module cdic_sample_player
  import cdic_audio_pkg::*;
#(
  parameter int unsigned SAMPLE_W        = PCM_W,
  parameter int unsigned FIFO_DEPTH_LOG2 = 4,
  parameter int unsigned PREFILL         = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       sample_tick37,
  input  logic                       sample_tick44,
  input  logic                       enable,
  input  logic                       rate_sel,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_mono,
  input  logic [SAMPLE_W-1:0]        in_left,
  input  logic [SAMPLE_W-1:0]        in_right,
  output logic [SAMPLE_W-1:0]        out_left,
  output logic [SAMPLE_W-1:0]        out_right,
  output logic                       out_strobe,
  output logic [FIFO_DEPTH_LOG2:0]   fill_level,
  output logic [7:0]                 underrun_count
);

  localparam logic [FIFO_DEPTH_LOG2:0] PREFILL_LVL = (FIFO_DEPTH_LOG2 + 1)'(PREFILL);

  player_state_e         state_q;
  logic                  rate_q;
  logic [SAMPLE_W-1:0]   out_left_q, out_right_q;
  logic                  out_strobe_q;
  logic [7:0]            underrun_q;

  logic                  tick, full, empty, push, pop, prefill_ok;
  logic [2*SAMPLE_W-1:0] push_data, head;

  assign tick       = (rate_q == RATE_44K1) ? sample_tick44 : sample_tick37;
  assign in_ready   = reset_n & ~full;
  assign push       = in_valid & in_ready;
  assign push_data  = {in_left, (in_mono ? in_left : in_right)};
  assign pop        = (state_q == StPlay) & enable & ~flush & tick & ~empty;
  assign prefill_ok = (fill_level >= PREFILL_LVL);

  cdic_sample_fifo #(
    .DATA_W     (2 * SAMPLE_W),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (flush),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .count     (fill_level)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      rate_q       <= RATE_37K8;
      out_left_q   <= '0;
      out_right_q  <= '0;
      out_strobe_q <= 1'b0;
      underrun_q   <= '0;
    end else begin
      out_strobe_q <= 1'b0;
      if (state_q == StIdle) rate_q <= rate_sel;
      if (flush || !enable) begin
        state_q     <= StIdle;
        out_left_q  <= '0;
        out_right_q <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            out_left_q  <= '0;
            out_right_q <= '0;
            state_q     <= StPrefill;
          end
          StPrefill: begin
            if (prefill_ok) state_q <= StPlay;
          end
          StPlay: begin
            if (tick) begin
              out_strobe_q <= 1'b1;
              if (!empty) begin
                out_left_q  <= head[2*SAMPLE_W-1:SAMPLE_W];
                out_right_q <= head[SAMPLE_W-1:0];
              end else begin
                state_q <= StUnderrun;
                if (underrun_q != 8'hFF) underrun_q <= underrun_q + 8'd1;
              end
            end
          end
          StUnderrun: begin
            if (tick) begin
              out_strobe_q <= 1'b1;
              if (underrun_q != 8'hFF) underrun_q <= underrun_q + 8'd1;
`ifdef CDIC_UNDERRUN_RAMP_EN
              out_left_q  <= {out_left_q[SAMPLE_W-1], out_left_q[SAMPLE_W-1:1]};
              out_right_q <= {out_right_q[SAMPLE_W-1], out_right_q[SAMPLE_W-1:1]};
`else
              out_left_q  <= out_left_q;
              out_right_q <= out_right_q;
`endif
            end
            if (prefill_ok) state_q <= StPlay;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign out_left       = out_left_q;
  assign out_right      = out_right_q;
  assign out_strobe     = out_strobe_q;
  assign underrun_count = underrun_q;

endmodule

// File: tb/tb_cdic_sample_player.sv
// Directed bench for cdic_sample_player: prefill, full FIFO, underrun, mono, flush, rate, reset.
module tb_cdic_sample_player;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        sample_tick37, sample_tick44, enable, rate_sel, flush;
  logic        in_valid, in_ready, in_mono, out_strobe;
  logic [15:0] in_left, in_right, out_left, out_right;
  logic [4:0]  fill_level;
  logic [7:0]  underrun_count;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef CDIC_UNDERRUN_RAMP_EN
  localparam logic [15:0] EXP_HOLD17 = 16'h0008;
  localparam logic [15:0] EXP_R1 = 16'h0080, EXP_R2 = 16'h0040, EXP_R3 = 16'h0020;
`else
  localparam logic [15:0] EXP_HOLD17 = 16'h0011;
  localparam logic [15:0] EXP_R1 = 16'h0100, EXP_R2 = 16'h0100, EXP_R3 = 16'h0100;
`endif

  always #5 clk = ~clk;

  cdic_sample_player dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .sample_tick37  (sample_tick37),
    .sample_tick44  (sample_tick44),
    .enable         (enable),
    .rate_sel       (rate_sel),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_mono        (in_mono),
    .in_left        (in_left),
    .in_right       (in_right),
    .out_left       (out_left),
    .out_right      (out_right),
    .out_strobe     (out_strobe),
    .fill_level     (fill_level),
    .underrun_count (underrun_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pair(input logic [15:0] l, input logic [15:0] r, input logic mono);
    in_valid = 1'b1;
    in_left  = l;
    in_right = r;
    in_mono  = mono;
    step();
    in_valid = 1'b0;
    in_mono  = 1'b0;
  endtask

  task automatic tick37();
    sample_tick37 = 1'b1;
    step();
    sample_tick37 = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; sample_tick37 = 1'b0; sample_tick44 = 1'b0; enable = 1'b0;
    rate_sel = 1'b0; flush = 1'b0; in_valid = 1'b0; in_mono = 1'b0;
    in_left = '0; in_right = '0;
    #12;
    check("rst_fill", fill_level, 0);
    check("rst_ready", in_ready, 0);
    check("rst_left", out_left, 0);
    check("rst_strobe", out_strobe, 0);
    check("rst_underrun", underrun_count, 0);
    reset_n = 1'b1;
    step();
    check("ready_after_rst", in_ready, 1);

    // Prefill with 1..8 while 44.1k ticks run; rate 0 is latched so they are ignored
    enable = 1'b1; rate_sel = 1'b0;
    step();
    sample_tick44 = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      push_pair(16'(i), 16'(100 + i), 1'b0);
      check("prefill_no_strobe", out_strobe, 0);
    end
    step();
    step();
    check("tick44_ignored", out_strobe, 0);
    check("fill_8", fill_level, 8);
    sample_tick44 = 1'b0;
    tick37();
    check("first_strobe", out_strobe, 1);
    check("first_left", out_left, 1);
    check("first_right", out_right, 101);
    check("fill_7", fill_level, 7);
    step();
    check("strobe_one_cycle", out_strobe, 0);

    // Fill to 16, refuse extra pushes even with a simultaneous pop
    for (int i = 9; i <= 17; i++) push_pair(16'(i), 16'(100 + i), 1'b0);
    check("full_ready", in_ready, 0);
    check("full_fill", fill_level, 16);
    push_pair(16'h7777, 16'h7777, 1'b0);
    check("full_refused", fill_level, 16);
    in_valid = 1'b1; in_left = 16'h7777; sample_tick37 = 1'b1;
    step();
    in_valid = 1'b0; sample_tick37 = 1'b0;
    check("full_pop_push_fill", fill_level, 15);
    check("full_pop_left", out_left, 2);

    // Drain down to one entry, then run into underrun
    for (int i = 3; i <= 16; i++) tick37();
    check("drain_left", out_left, 16);
    check("drain_fill", fill_level, 1);
    tick37();
    check("last_pop_left", out_left, 17);
    tick37();
    check("underrun_strobe", out_strobe, 1);
    check("underrun_hold1", out_left, 17);
    tick37();
    check("underrun_hold2", out_left, EXP_HOLD17);
    check("underrun_cnt2", underrun_count, 2);
    for (int i = 0; i < 8; i++) push_pair(16'(16'h20 + i), 16'(16'h30 + i), 1'b0);
    step();
    tick37();
    check("resume_left", out_left, 16'h20);
    check("resume_right", out_right, 16'h30);
    check("resume_underrun", underrun_count, 2);
    check("resume_fill", fill_level, 7);

    // Mono duplicates left into right
    push_pair(16'h1234, 16'hFFFF, 1'b1);
    for (int i = 0; i < 7; i++) tick37();
    tick37();
    check("mono_left", out_left, 16'h1234);
    check("mono_right", out_right, 16'h1234);
    check("mono_fill", fill_level, 0);

    // Underrun decay (or hold) from 0x0100
    push_pair(16'h0100, 16'h0000, 1'b1);
    tick37();
    check("ramp_src", out_left, 16'h0100);
    tick37();
    check("ramp_first", out_left, 16'h0100);
    tick37();
    check("ramp_1", out_left, EXP_R1);
    tick37();
    check("ramp_2", out_left, EXP_R2);
    tick37();
    check("ramp_3", out_right, EXP_R3);
    check("ramp_underrun", underrun_count, 6);

    // Negative one is a fixed point of the decay
    for (int i = 0; i < 8; i++) push_pair(16'hFFFF, 16'h0000, 1'b1);
    step();
    for (int i = 0; i < 8; i++) tick37();
    tick37();
    tick37();
    check("neg_left", out_left, 16'hFFFF);
    check("neg_right", out_right, 16'hFFFF);
    check("neg_underrun", underrun_count, 8);

    // Flush mid-play together with a push
    for (int i = 0; i < 8; i++) push_pair(16'(16'h40 + i), 16'(16'h50 + i), 1'b0);
    step();
    tick37();
    check("preflush_left", out_left, 16'h40);
    flush = 1'b1; in_valid = 1'b1; in_left = 16'h0099;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_fill", fill_level, 0);
    check("flush_left", out_left, 0);
    check("flush_right", out_right, 0);
    check("flush_strobe", out_strobe, 0);
    check("flush_underrun_kept", underrun_count, 8);
    tick37();
    check("flush_no_strobe", out_strobe, 0);

    // Disable keeps FIFO, then re-enable at 44.1 kHz
    for (int i = 0; i < 8; i++) push_pair(16'(16'h60 + i), 16'(16'h70 + i), 1'b0);
    step();
    tick37();
    check("replay_left", out_left, 16'h60);
    enable = 1'b0;
    step();
    check("disable_left", out_left, 0);
    check("disable_fill", fill_level, 7);
    rate_sel = 1'b1;
    step();
    enable = 1'b1;
    step();
    rate_sel = 1'b0;
    push_pair(16'h0068, 16'h0078, 1'b0);
    step();
    tick37();
    check("rate44_ignores_37", out_strobe, 0);
    sample_tick44 = 1'b1;
    step();
    sample_tick44 = 1'b0;
    check("rate44_strobe", out_strobe, 1);
    check("rate44_left", out_left, 16'h61);
    check("rate44_fill", fill_level, 7);

    // Asynchronous reset while the strobe is high
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_left", out_left, 0);
    check("async_rst_right", out_right, 0);
    check("async_rst_strobe", out_strobe, 0);
    check("async_rst_fill", fill_level, 0);
    check("async_rst_ready", in_ready, 0);
    check("async_rst_underrun", underrun_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cdic_sample_player.md
Name: cdic_sample_player

Overview:
- Downstream consumer of the CDIC audio tick generator.
- Buffers decoded stereo PCM from the ADPCM decoder in a small FIFO.
- Releases one stereo pair per selected sample tick (37.8 kHz or 44.1 kHz) toward the audio mixer/DAC path.
- Handles prefill, underrun recovery and flush so the output timing stays locked to the tick generator.

Parameters:
- SAMPLE_W, 16, sample width per channel (signed two's complement).
- FIFO_DEPTH_LOG2, 4, log2 of FIFO depth in stereo pairs (default 16 entries).
- PREFILL, 8, fill level required before playback starts or resumes; legal range 1..2**FIFO_DEPTH_LOG2.

Ports:
- clk  in  1  system clock (30 MHz domain; ticks already synchronized to it).
- reset_n  in  1  asynchronous, active-low reset.
- sample_tick37  in  1  single-cycle 37.8 kHz tick.
- sample_tick44  in  1  single-cycle 44.1 kHz tick.
- enable  in  1  playback enable.
- rate_sel  in  1  0 = 37.8 kHz, 1 = 44.1 kHz; latched only in IDLE.
- flush  in  1  synchronous clear of FIFO and state.
- in_valid  in  1  input pair valid.
- in_ready  out  1  FIFO can accept.
- in_mono  in  1  duplicate in_left into the right channel.
- in_left  in  SAMPLE_W  left sample.
- in_right  in  SAMPLE_W  right sample.
- out_left  out  SAMPLE_W  current left output.
- out_right  out  SAMPLE_W  current right output.
- out_strobe  out  1  one-cycle pulse when the outputs update.
- fill_level  out  FIFO_DEPTH_LOG2+1  entries in FIFO.
- underrun_count  out  8  saturating count of underrun ticks.

Behaviour:
- Reset (reset_n low, async):
  - FIFO empty; fill_level=0; state IDLE; latched rate = 0.
  - out_left=out_right=0; out_strobe=0; underrun_count=0.
  - in_ready=0 while in reset.
- Tick selection: tick = latched_rate ? sample_tick44 : sample_tick37.
  - rate_sel is latched every cycle in IDLE and frozen in all other states.
- Input handshake:
  - Push occurs when in_valid && in_ready.
  - in_ready = !full, derived from the registered count.
  - When full, a push is refused even if a pop happens in the same cycle.
  - With in_mono=1 the stored right sample equals in_left.
  - Push and pop in the same cycle leave the count unchanged.
- States:
  - IDLE: outputs held at 0, no strobe. Go to PREFILL when enable=1. The FIFO still accepts pushes.
  - PREFILL: no strobe. Go to PLAY on the first cycle fill_level >= PREFILL.
  - PLAY: on each tick, pop the head. Next cycle, out_left/out_right = popped pair and out_strobe=1 (latency 1 cycle from tick). A tick arriving with the FIFO empty means no pop: go to UNDERRUN, strobe anyway with the held value, and increment underrun_count.
  - UNDERRUN: every tick strobes the held outputs and increments underrun_count (saturates at 255). Go to PLAY when fill_level >= PREFILL; the next tick then pops.
- enable=0 in any state: go to IDLE next cycle and zero the outputs; FIFO contents are kept.
- flush=1: highest priority below reset.
  - Next cycle: FIFO empty, state IDLE, outputs 0.
  - A push in the same cycle is discarded.
  - underrun_count is kept.
- Pointers wrap modulo 2**FIFO_DEPTH_LOG2.
- fill_level is in the range 0..2**FIFO_DEPTH_LOG2.

Optional Feature:
- CDIC_UNDERRUN_RAMP_EN defined:
  - In UNDERRUN, each tick replaces each output with that output arithmetic-shifted right by 1 (sign-preserving decay toward 0; -1 stays -1).
  - This avoids DC clicks when data runs out.
- CDIC_UNDERRUN_RAMP_EN undefined:
  - Outputs hold the last popped value exactly.

Decomposition:
- Shared package cdic_audio_pkg:
  - typedef for the stereo pair struct (left, right at SAMPLE_W).
  - typedef enum for player states (IDLE, PREFILL, PLAY, UNDERRUN).
  - rate-select encoding constants.
- One sub-module cdic_sample_fifo: synchronous single-clock FIFO with push/pop, full/empty and count, async active-low reset.
- FSM, tick mux and output registers stay in the top module.

Test Plan:
- Reset, then enable=1, rate_sel=0, push 8 pairs (1..8).
  - No strobe before the 8th push.
  - First sample_tick37 gives out_strobe 1 cycle later with out_left=1.
  - sample_tick44 pulses are ignored.
- Push 16 pairs with no ticks.
  - in_ready=0 and fill_level=16.
  - A 17th in_valid is not accepted.
  - A tick plus in_valid in the same cycle while full gives fill_level=15 next cycle.
- In PLAY with 1 entry, apply 3 ticks.
  - The first tick pops.
  - The next 2 strobe the held value; underrun_count=2.
  - After pushing 8 more pairs, the next tick pops new data.
- in_mono=1, in_left=0x1234, in_right=0xFFFF.
  - After playback, out_left=out_right=0x1234.
- Mid-PLAY, assert flush together with in_valid.
  - Next cycle: fill_level=0, state IDLE, outputs 0, no strobe on subsequent ticks.
  - Assert reset_n=0 asynchronously mid-strobe: all outputs 0 immediately.
- With CDIC_UNDERRUN_RAMP_EN, last sample 0x0100 and FIFO empty.
  - Successive tick strobes give 0x0080, 0x0040, 0x0020.
  - Last sample 0xFFFF stays 0xFFFF.
